// File: rtl/fb_pkg.sv
// Shared types and width helpers for the framebuffer arbiter and its round-robin selector.
package fb_pkg;

    typedef enum logic [1:0] {
        SW_IDLE    = 2'd0,
        SW_PENDING = 2'd1,
        SW_SWAP    = 2'd2
    } swap_state_e;

    localparam int FB_W_DEF = 400;
    localparam int FB_H_DEF = 300;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One extra MSB selects which of the two buffers is addressed.
    function automatic int addr_w(input int w, input int h);
        return 1 + $clog2(w * h);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin client selector; priority starts at the client after the last one granted.
module rr_arbiter
    import fb_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    localparam int PTR_W = coord_w(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] gnt
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;

    // Every grant goes to a valid requester, so a grant is always a transfer.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (en && !found && req[i] && (((int'(ptr_q) + k) % NUM_CLIENTS) == i)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                    ptr_d  = PTR_W'((i + 1) % NUM_CLIENTS);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: scanout has absolute priority, draw clients share the rest round-robin.
// Double buffering with vblank-synchronised swap is enabled by FB_ARBITER_DOUBLE_BUFFER_EN.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int FB_W        = FB_W_DEF,
    parameter int FB_H        = FB_H_DEF,
    parameter int COLOR_BITS  = 12,
    parameter int NUM_CLIENTS = 2,
    localparam int XW     = coord_w(FB_W),
    localparam int YW     = coord_w(FB_H),
    localparam int ADDR_W = addr_w(FB_W, FB_H)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              so_rd_en,
    input  logic [XW-1:0]                     so_rd_x,
    input  logic [YW-1:0]                     so_rd_y,
    output logic                              so_valid,
    output logic [COLOR_BITS-1:0]             so_color,
    input  logic [NUM_CLIENTS-1:0]            req_valid,
    input  logic [NUM_CLIENTS-1:0]            req_we,
    input  logic [NUM_CLIENTS*XW-1:0]         req_x,
    input  logic [NUM_CLIENTS*YW-1:0]         req_y,
    input  logic [NUM_CLIENTS*COLOR_BITS-1:0] req_wdata,
    output logic [NUM_CLIENTS-1:0]            req_ready,
    output logic [NUM_CLIENTS-1:0]            rsp_valid,
    output logic [COLOR_BITS-1:0]             rsp_rdata,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [ADDR_W-1:0]                 mem_addr,
    output logic [COLOR_BITS-1:0]             mem_wdata,
    input  logic [COLOR_BITS-1:0]             mem_rdata,
    input  logic                              vblank,
    input  logic                              swap_req,
    output logic                              swap_done,
    output logic                              front_sel
);

    localparam int LIN_W = ADDR_W - 1;

    logic                   back_sel;
    logic                   clients_ok;
    logic [NUM_CLIENTS-1:0] gnt;
    logic [XW-1:0]          sel_x;
    logic [YW-1:0]          sel_y;
    logic                   sel_we;
    logic [COLOR_BITS-1:0]  sel_wdata;
    logic                   sel_any;
    logic                   in_range;
    logic                   so_valid_q, so_valid_d;
    logic [NUM_CLIENTS-1:0] rsp_valid_q, rsp_valid_d;
    logic                   oor_q, oor_d;

    function automatic logic [LIN_W-1:0] lin_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
        return LIN_W'(y) * LIN_W'(FB_W) + LIN_W'(x);
    endfunction

    rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (reset_n & clients_ok & ~so_rd_en),
        .req     (req_valid),
        .gnt     (gnt)
    );

    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_we    = 1'b0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (gnt[i]) begin
                sel_x     = req_x[i*XW +: XW];
                sel_y     = req_y[i*YW +: YW];
                sel_we    = req_we[i];
                sel_wdata = req_wdata[i*COLOR_BITS +: COLOR_BITS];
            end
        end
    end

    assign sel_any  = |gnt;
    assign in_range = (32'(sel_x) < FB_W) && (32'(sel_y) < FB_H);

    // Out-of-range client reads skip the RAM but still owe a (zero) response.
    always_comb begin
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        req_ready   = '0;
        so_valid_d  = 1'b0;
        rsp_valid_d = '0;
        oor_d       = 1'b0;
        if (reset_n && so_rd_en) begin
            mem_en     = 1'b1;
            mem_addr   = {front_sel, lin_addr(so_rd_x, so_rd_y)};
            so_valid_d = 1'b1;
        end else if (sel_any) begin
            req_ready = gnt;
            mem_en    = in_range;
            mem_we    = in_range & sel_we;
            mem_addr  = {back_sel, lin_addr(sel_x, sel_y)};
            mem_wdata = sel_wdata;
            if (!sel_we) begin
                rsp_valid_d = gnt;
                oor_d       = ~in_range;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            so_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            oor_q       <= 1'b0;
        end else begin
            so_valid_q  <= so_valid_d;
            rsp_valid_q <= rsp_valid_d;
            oor_q       <= oor_d;
        end
    end

    assign so_valid  = so_valid_q;
    assign so_color  = mem_rdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = oor_q ? '0 : mem_rdata;

`ifdef FB_ARBITER_DOUBLE_BUFFER_EN
    swap_state_e state_q, state_d;
    logic        front_q, front_d;
    logic        vblank_q;
    logic        vblank_rise;

    assign vblank_rise = vblank & ~vblank_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SW_IDLE;
            front_q  <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            front_q  <= front_d;
            vblank_q <= vblank;
        end
    end

    // A vblank edge coinciding with swap_req in IDLE is not used; the swap waits for the next edge.
    always_comb begin
        state_d = state_q;
        front_d = front_q;
        case (state_q)
            SW_IDLE:    if (swap_req) state_d = SW_PENDING;
            SW_PENDING: if (vblank_rise) state_d = SW_SWAP;
            SW_SWAP: begin
                state_d = SW_IDLE;
                front_d = ~front_q;
            end
            default:    state_d = SW_IDLE;
        endcase
    end

    assign front_sel  = front_q;
    assign back_sel   = ~front_q;
    assign swap_done  = (state_q == SW_SWAP);
    assign clients_ok = (state_q != SW_SWAP);
`else
    logic swap_done_q, swap_done_d;
    logic unused_vblank;

    always_comb swap_done_d = swap_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            swap_done_q <= 1'b0;
        end else begin
            swap_done_q <= swap_done_d;
        end
    end

    assign front_sel     = 1'b0;
    assign back_sel      = 1'b0;
    assign swap_done     = swap_done_q;
    assign clients_ok    = 1'b1;
    assign unused_vblank = vblank;
`endif

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): FB_W, 400, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_H, 300, framebuffer height in pixels.
REQ-003 SHALL have parameter COLOR_BITS, 12, pixel width.
REQ-004 SHALL have parameter NUM_CLIENTS, 2, number of draw requesters; derived ADDR_W = 1 + $clog2(FB_W*FB_H).
REQ-005 SHALL have ports (name, direction, width, meaning): clk, in, 1, sole clock; reset_n, in, 1, asynchronous active-low reset.
REQ-006 SHALL have so_rd_en in 1, so_rd_x in $clog2(FB_W), so_rd_y in $clog2(FB_H), so_valid out 1, so_color out COLOR_BITS: scanout read port.
REQ-007 SHALL have req_valid in NUM_CLIENTS, req_we in NUM_CLIENTS, req_x in NUM_CLIENTS*$clog2(FB_W), req_y in NUM_CLIENTS*$clog2(FB_H), req_wdata in NUM_CLIENTS*COLOR_BITS, req_ready out NUM_CLIENTS: draw client requests.
REQ-008 SHALL have rsp_valid out NUM_CLIENTS and rsp_rdata out COLOR_BITS: read responses to draw clients.
REQ-009 SHALL have mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out COLOR_BITS, mem_rdata in COLOR_BITS: single-port framebuffer RAM with 1-cycle read latency.
REQ-010 SHALL have vblank in 1, swap_req in 1, swap_done out 1, front_sel out 1: buffer swap control.

Function
REQ-011 SHALL issue at most one mem access per cycle; mem_addr = {buffer_bit, y*FB_W + x}.
REQ-012 SHALL give so_rd_en absolute priority; scanout reads the front buffer (buffer_bit = front_sel); all req_ready SHALL be 0 in that cycle.
REQ-013 SHALL assert so_valid exactly 1 cycle after so_rd_en, with so_color = mem_rdata.
REQ-014 SHALL grant one draw client per free cycle, round-robin starting after the last granted client; req_ready[i] high only for the granted i; transfer = req_valid[i] & req_ready[i].
REQ-015 SHALL route draw accesses to the back buffer (buffer_bit = ~front_sel).
REQ-016 SHALL assert rsp_valid[i] exactly 1 cycle after a granted read by client i, with rsp_rdata = mem_rdata; writes produce no response.
REQ-017 SHALL accept out-of-range client x/y (x >= FB_W or y >= FB_H), drive mem_en = 0 for them, and return rsp_rdata = 0 for reads.
REQ-018 SHALL run a swap FSM: IDLE -> PENDING on swap_req; PENDING -> SWAP on a vblank rising edge; SWAP -> IDLE after 1 cycle, toggling front_sel and pulsing swap_done for 1 cycle.
REQ-019 SHALL deassert all req_ready during SWAP; a read granted the cycle before SWAP SHALL still complete from the old back buffer.
REQ-020 SHALL ignore swap_req while in PENDING or SWAP (no queuing).
REQ-021 SHALL, if swap_req and a vblank rising edge coincide in IDLE, enter PENDING only and wait for the next rising edge.

Reset
REQ-022 SHALL, on reset_n low, asynchronously clear: front_sel 0, FSM IDLE, round-robin pointer to client 0, and so_valid, rsp_valid, req_ready, mem_en, mem_we, swap_done all 0; in-flight responses are discarded.

Configuration
REQ-023 SHALL support macro FB_ARBITER_DOUBLE_BUFFER_EN: when defined, behaviour follows REQ-015 and REQ-018..021.
REQ-024 SHALL, when the macro is undefined, tie buffer_bit and front_sel to 0, omit the FSM, and pulse swap_done 1 cycle after swap_req without stalling clients.

Structure
REQ-025 SHALL place the swap FSM state enum and ADDR_W/coordinate-width helper constants in shared package fb_pkg.
REQ-026 SHALL implement client selection in sub-module rr_arbiter (NUM_CLIENTS request/grant vectors plus a pointer update on transfer).

Verification
REQ-027 Scanout only: so_rd_en=1, x=3, y=2, front_sel=0 -> mem_addr=803; so_valid next cycle with the RAM value.
REQ-028 Contention: clients 0 and 1 both valid while so_rd_en is held for 2 cycles -> req_ready=0 for both; then grants alternate 0, 1, 0.
REQ-029 Client 1 writes 0xABC at (10,0), then reads it back -> rsp_valid[1] 1 cycle after the read grant, rsp_rdata=0xABC, address bit ADDR_W-1 = 1.
REQ-030 swap_req, then vblank rises 5 cycles later -> swap_done pulses 1 cycle after the edge, front_sel=1, req_ready=0 during the SWAP cycle.
REQ-031 Out-of-range read x=FB_W -> mem_en=0, rsp_valid=1 next cycle, rsp_rdata=0.
REQ-032 reset_n pulled low while in PENDING with a read in flight -> front_sel=0, FSM IDLE, no rsp_valid after reset is released.
